// File: rtl/pipe_ctrl_dx.sv
// RV32IM decode control with the D->E control pipeline register.
// Sequences multi-cycle M-extension ops in E and stalls the front end while they run.
module pipe_ctrl_dx #(
    parameter int unsigned MUL_LAT   = 2,
    parameter int unsigned DIV_LAT   = 34,
    parameter int unsigned ALUCTRL_W = 4,
    parameter int unsigned CNT_W     = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [6:0]           i_ctrl_op,
    input  logic [2:0]           i_ctrl_funct3,
    input  logic [6:0]           i_ctrl_funct7,
    input  logic                 i_stallE,
    input  logic                 i_flushE,
    output logic [1:0]           o_ctrl_ImmSrcD,
    output logic                 o_ctrl_RegWriteE,
    output logic [1:0]           o_ctrl_ResultSrcE,
    output logic                 o_ctrl_MemWriteE,
    output logic                 o_ctrl_JumpE,
    output logic                 o_ctrl_BranchE,
    output logic [ALUCTRL_W-1:0] o_ctrl_ALUControlE,
    output logic                 o_ctrl_ALUSrcE,
    output logic [3:0]           o_ctrl_mem_byte_selE,
    output logic                 o_ctrl_mem_unsgnE,
    output logic                 o_ctrl_mdu_selE,
    output logic [2:0]           o_ctrl_mdu_opE,
    output logic                 o_ctrl_mdu_startE,
    output logic                 o_ctrl_mdu_doneE,
    output logic                 o_ctrl_busy,
    output logic                 o_ctrl_illegalE
);

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_I_OP   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_R_OP   = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
    localparam logic [3:0] ALU_CTRL_AND  = 4'd2;
    localparam logic [3:0] ALU_CTRL_OR   = 4'd3;
    localparam logic [3:0] ALU_CTRL_XOR  = 4'd4;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'd5;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'd6;
    localparam logic [3:0] ALU_CTRL_SLL  = 4'd7;
    localparam logic [3:0] ALU_CTRL_SRL  = 4'd8;
    localparam logic [3:0] ALU_CTRL_SRA  = 4'd9;
    localparam logic [3:0] ALU_CTRL_PASS = 4'd10;

    localparam logic [1:0] SRC_IMM_I = 2'b00;
    localparam logic [1:0] SRC_IMM_S = 2'b01;
    localparam logic [1:0] SRC_IMM_B = 2'b10;
    localparam logic [1:0] SRC_IMM_J = 2'b11;

    localparam logic [1:0] SRC_RD_ALU = 2'b00;
    localparam logic [1:0] SRC_RD_MEM = 2'b01;
    localparam logic [1:0] SRC_RD_PC4 = 2'b10;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    typedef struct packed {
        logic                 reg_write;
        logic [1:0]           result_src;
        logic                 mem_write;
        logic                 jump;
        logic                 branch;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic                 alu_src;
        logic [3:0]           byte_sel;
        logic                 mem_unsgn;
        logic                 mdu_sel;
        logic [2:0]           mdu_op;
        logic                 illegal;
    } ctrl_t;

    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c           = '0;
        c.alu_ctrl  = ALUCTRL_W'(ALU_CTRL_ADD);
        c.byte_sel  = 4'b1111;
        return c;
    endfunction

    function automatic logic [ALUCTRL_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] a;
        case (f3)
            3'b000:  a = alt ? ALU_CTRL_SUB : ALU_CTRL_ADD;
            3'b001:  a = ALU_CTRL_SLL;
            3'b010:  a = ALU_CTRL_SLT;
            3'b011:  a = ALU_CTRL_SLTU;
            3'b100:  a = ALU_CTRL_XOR;
            3'b101:  a = alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
            3'b110:  a = ALU_CTRL_OR;
            default: a = ALU_CTRL_AND;
        endcase
        return ALUCTRL_W'(a);
    endfunction

    function automatic logic [3:0] byte_sel_from_f3(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    ctrl_t            dec;
    ctrl_t            ctrl_e;
    logic [1:0]       imm_src;
    logic             illegal;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat_last;
    logic             flush_pend;
    logic             hold;
    logic             start;
    logic             done;
    logic             busy;

    // D-stage decode; illegal encodings collapse to a flagged bubble.
    always_comb begin
        dec     = bubble_ctrl();
        imm_src = SRC_IMM_I;
        illegal = 1'b0;
        case (i_ctrl_op)
            OPCODE_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = SRC_RD_MEM;
                dec.alu_src    = 1'b1;
                dec.byte_sel   = byte_sel_from_f3(i_ctrl_funct3);
                dec.mem_unsgn  = i_ctrl_funct3[2];
                illegal        = (i_ctrl_funct3 == 3'b011) || (i_ctrl_funct3 == 3'b110) ||
                                 (i_ctrl_funct3 == 3'b111);
            end
            OPCODE_STORE: begin
                imm_src        = SRC_IMM_S;
                dec.mem_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.byte_sel   = byte_sel_from_f3(i_ctrl_funct3);
                illegal        = (i_ctrl_funct3 >= 3'b011);
            end
            OPCODE_R_OP: begin
                dec.reg_write = 1'b1;
                if (i_ctrl_funct7 == F7_BASE) begin
                    dec.alu_ctrl = alu_from_f3(i_ctrl_funct3, 1'b0);
                end else if (i_ctrl_funct7 == F7_ALT) begin
                    dec.alu_ctrl = alu_from_f3(i_ctrl_funct3, 1'b1);
                    illegal      = (i_ctrl_funct3 != 3'b000) && (i_ctrl_funct3 != 3'b101);
                end else if (i_ctrl_funct7 == F7_MDU) begin
                    dec.mdu_sel = 1'b1;
                    dec.mdu_op  = i_ctrl_funct3;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPCODE_I_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_from_f3(i_ctrl_funct3,
                                            (i_ctrl_funct3 == 3'b101) && i_ctrl_funct7[5]);
            end
            OPCODE_BRANCH: begin
                imm_src      = SRC_IMM_B;
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALUCTRL_W'(ALU_CTRL_SUB);
                illegal      = (i_ctrl_funct3 == 3'b010) || (i_ctrl_funct3 == 3'b011);
            end
            OPCODE_JAL: begin
                imm_src        = SRC_IMM_J;
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = SRC_RD_PC4;
            end
            OPCODE_JALR: begin
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = SRC_RD_PC4;
                dec.alu_src    = 1'b1;
            end
            // U-type immediates come straight from instr[31:12] in the datapath.
            OPCODE_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALUCTRL_W'(ALU_CTRL_PASS);
            end
            OPCODE_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OPCODE_FENCE, OPCODE_SYSTEM: begin
                dec = bubble_ctrl();
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec         = bubble_ctrl();
            dec.illegal = 1'b1;
        end
    end

    assign lat_last = ctrl_e.mdu_op[2] ? DIV_LAST : MUL_LAST;
    assign start    = ctrl_e.mdu_sel && (cnt == '0) && (state == IDLE);
    assign done     = ctrl_e.mdu_sel && (cnt == lat_last);
    assign busy     = ctrl_e.mdu_sel && (cnt != lat_last);
    assign hold     = i_stallE || busy;

    // E register, M-op sequencer and deferred flush.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            ctrl_e     <= bubble_ctrl();
            state      <= IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start && (lat_last != '0)) state <= RUN;
                RUN:     if (cnt == lat_last) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (hold) begin
                flush_pend <= flush_pend || i_flushE;
                if (ctrl_e.mdu_sel && (cnt != lat_last)) cnt <= cnt + CNT_W'(1);
            end else begin
                flush_pend <= 1'b0;
                cnt        <= '0;
                ctrl_e     <= (i_flushE || flush_pend) ? bubble_ctrl() : dec;
            end
        end
    end

    assign o_ctrl_ImmSrcD       = imm_src;
    assign o_ctrl_RegWriteE     = ctrl_e.reg_write;
    assign o_ctrl_ResultSrcE    = ctrl_e.result_src;
    assign o_ctrl_MemWriteE     = ctrl_e.mem_write;
    assign o_ctrl_JumpE         = ctrl_e.jump;
    assign o_ctrl_BranchE       = ctrl_e.branch;
    assign o_ctrl_ALUControlE   = ctrl_e.alu_ctrl;
    assign o_ctrl_ALUSrcE       = ctrl_e.alu_src;
    assign o_ctrl_mem_byte_selE = ctrl_e.byte_sel;
    assign o_ctrl_mem_unsgnE    = ctrl_e.mem_unsgn;
    assign o_ctrl_mdu_selE      = ctrl_e.mdu_sel;
    assign o_ctrl_mdu_opE       = ctrl_e.mdu_op;
    assign o_ctrl_mdu_startE    = start;
    assign o_ctrl_mdu_doneE     = done;
    assign o_ctrl_busy          = busy;
    assign o_ctrl_illegalE      = ctrl_e.illegal;

endmodule

// File: tb/tb_pipe_ctrl_dx.sv
// Directed bench for pipe_ctrl_dx with MUL_LAT=2, DIV_LAT=4.
module tb_pipe_ctrl_dx;

    logic       clk = 1'b0;
    logic       rstn;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       stall;
    logic       flush;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [3:0] byte_sel;
    logic       mem_unsgn;
    logic       mdu_sel;
    logic [2:0] mdu_op;
    logic       mdu_start;
    logic       mdu_done;
    logic       busy;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl_dx #(.MUL_LAT(2), .DIV_LAT(4), .ALUCTRL_W(4), .CNT_W(6)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_ctrl_op(op), .i_ctrl_funct3(f3), .i_ctrl_funct7(f7),
        .i_stallE(stall), .i_flushE(flush),
        .o_ctrl_ImmSrcD(imm_src), .o_ctrl_RegWriteE(reg_write), .o_ctrl_ResultSrcE(result_src),
        .o_ctrl_MemWriteE(mem_write), .o_ctrl_JumpE(jump), .o_ctrl_BranchE(branch),
        .o_ctrl_ALUControlE(alu_ctrl), .o_ctrl_ALUSrcE(alu_src), .o_ctrl_mem_byte_selE(byte_sel),
        .o_ctrl_mem_unsgnE(mem_unsgn), .o_ctrl_mdu_selE(mdu_sel), .o_ctrl_mdu_opE(mdu_op),
        .o_ctrl_mdu_startE(mdu_start), .o_ctrl_mdu_doneE(mdu_done), .o_ctrl_busy(busy),
        .o_ctrl_illegalE(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic [6:0] g);
        op = o; f3 = f; f7 = g;
    endtask

    task automatic test_reset();
        rstn = 1'b0; stall = 1'b0; flush = 1'b0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        tick(); tick();
        checks++; if (reg_write !== 1'b0) begin failures++; $display("FAIL rst_regwrite got=%b exp=0", reg_write); end
        checks++; if (alu_ctrl !== 4'd0) begin failures++; $display("FAIL rst_aluctrl got=%0d exp=0", alu_ctrl); end
        checks++; if (byte_sel !== 4'b1111) begin failures++; $display("FAIL rst_bytesel got=%b exp=1111", byte_sel); end
        checks++; if ({busy, mdu_start, mdu_sel, illegal} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {busy, mdu_start, mdu_sel, illegal}); end
    endtask

    task automatic test_alu_mem();
        rstn = 1'b1;
        set_instr(7'b0110011, 3'b000, 7'b0000000);  // add
        tick();
        checks++; if ({reg_write, alu_src, busy, result_src} !== 5'b10000) begin failures++; $display("FAIL add_ctrl got=%b exp=10000", {reg_write, alu_src, busy, result_src}); end
        checks++; if (alu_ctrl !== 4'd0) begin failures++; $display("FAIL add_aluctrl got=%0d exp=0", alu_ctrl); end
        set_instr(7'b0110011, 3'b000, 7'b0100000);  // sub
        tick();
        checks++; if (alu_ctrl !== 4'd1) begin failures++; $display("FAIL sub_aluctrl got=%0d exp=1", alu_ctrl); end
        set_instr(7'b0000011, 3'b100, 7'b0000000);  // lbu
        #1;
        checks++; if (imm_src !== 2'b00) begin failures++; $display("FAIL lbu_immsrc got=%b exp=00", imm_src); end
        tick();
        checks++; if ({result_src, alu_src, byte_sel, mem_unsgn} !== 8'b01_1_0001_1) begin failures++; $display("FAIL lbu_ctrl got=%b exp=01100011", {result_src, alu_src, byte_sel, mem_unsgn}); end
        set_instr(7'b0100011, 3'b001, 7'b0000000);  // sh
        #1;
        checks++; if (imm_src !== 2'b01) begin failures++; $display("FAIL sh_immsrc got=%b exp=01", imm_src); end
        tick();
        checks++; if ({mem_write, reg_write, byte_sel} !== 6'b10_0011) begin failures++; $display("FAIL sh_ctrl got=%b exp=100011", {mem_write, reg_write, byte_sel}); end
        set_instr(7'b1101111, 3'b000, 7'b0000000);  // jal
        tick();
        checks++; if ({jump, reg_write, result_src} !== 4'b1110) begin failures++; $display("FAIL jal_ctrl got=%b exp=1110", {jump, reg_write, result_src}); end
    endtask

    task automatic test_mul();
        set_instr(7'b0110011, 3'b000, 7'b0000001);  // mul
        tick();
        checks++; if ({mdu_sel, mdu_start, busy, mdu_done} !== 4'b1110) begin failures++; $display("FAIL mul_c1 got=%b exp=1110", {mdu_sel, mdu_start, busy, mdu_done}); end
        set_instr(7'b0110011, 3'b000, 7'b0000000);  // add waits in D
        tick();
        checks++; if ({mdu_sel, mdu_start, busy, mdu_done} !== 4'b1001) begin failures++; $display("FAIL mul_c2 got=%b exp=1001", {mdu_sel, mdu_start, busy, mdu_done}); end
        tick();
        checks++; if ({mdu_sel, reg_write, mdu_done} !== 3'b010) begin failures++; $display("FAIL mul_c3 got=%b exp=010", {mdu_sel, reg_write, mdu_done}); end
    endtask

    task automatic test_back_to_back();
        set_instr(7'b0110011, 3'b001, 7'b0000001);  // mulh
        tick(); tick();
        checks++; if (mdu_done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", mdu_done); end
        set_instr(7'b0110011, 3'b011, 7'b0000001);  // mulhu follows directly
        tick();
        checks++; if ({mdu_sel, mdu_start, busy, mdu_op} !== 6'b111_011) begin failures++; $display("FAIL b2b_start2 got=%b exp=111011", {mdu_sel, mdu_start, busy, mdu_op}); end
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        tick(); tick();
        checks++; if ({mdu_sel, reg_write} !== 2'b01) begin failures++; $display("FAIL b2b_after got=%b exp=01", {mdu_sel, reg_write}); end
    endtask

    task automatic test_div();
        set_instr(7'b0110011, 3'b101, 7'b0000001);  // divu
        tick();
        checks++; if ({mdu_start, busy, mdu_op} !== 5'b11_101) begin failures++; $display("FAIL div_c1 got=%b exp=11101", {mdu_start, busy, mdu_op}); end
        set_instr(7'b0110011, 3'b000, 7'b0100000);  // sub waits in D
        tick();
        checks++; if ({mdu_start, busy, mdu_done} !== 3'b010) begin failures++; $display("FAIL div_c2 got=%b exp=010", {mdu_start, busy, mdu_done}); end
        tick();
        checks++; if ({busy, mdu_done} !== 2'b10) begin failures++; $display("FAIL div_c3 got=%b exp=10", {busy, mdu_done}); end
        tick();
        checks++; if ({busy, mdu_done, mdu_sel} !== 3'b011) begin failures++; $display("FAIL div_c4 got=%b exp=011", {busy, mdu_done, mdu_sel}); end
        tick();
        checks++; if ({mdu_sel, alu_ctrl} !== 5'b0_0001) begin failures++; $display("FAIL div_next got=%b exp=00001", {mdu_sel, alu_ctrl}); end
    endtask

    task automatic test_div_flush();
        set_instr(7'b0110011, 3'b100, 7'b0000001);  // div
        tick();
        set_instr(7'b0110011, 3'b000, 7'b0000000);  // add waits in D
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if ({busy, mdu_sel} !== 2'b11) begin failures++; $display("FAIL dflush_c3 got=%b exp=11", {busy, mdu_sel}); end
        tick();
        checks++; if (mdu_done !== 1'b1) begin failures++; $display("FAIL dflush_done got=%b exp=1", mdu_done); end
        tick();
        checks++; if ({reg_write, mdu_sel, alu_ctrl} !== 6'b00_0000) begin failures++; $display("FAIL dflush_bubble got=%b exp=000000", {reg_write, mdu_sel, alu_ctrl}); end
        tick();
        checks++; if (reg_write !== 1'b1) begin failures++; $display("FAIL dflush_reload got=%b exp=1", reg_write); end
    endtask

    task automatic test_reset_run();
        set_instr(7'b0110011, 3'b111, 7'b0000001);  // remu
        tick(); tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rrun_busy got=%b exp=1", busy); end
        rstn = 1'b0;
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        tick();
        checks++; if ({reg_write, mdu_sel, busy, mdu_start, mdu_done, byte_sel} !== 9'b00000_1111) begin failures++; $display("FAIL rrun_bubble got=%b exp=000001111", {reg_write, mdu_sel, busy, mdu_start, mdu_done, byte_sel}); end
        rstn = 1'b1;
        tick();
        checks++; if ({reg_write, busy} !== 2'b10) begin failures++; $display("FAIL rrun_resume got=%b exp=10", {reg_write, busy}); end
    endtask

    task automatic test_illegal();
        set_instr(7'h7F, 3'b000, 7'b0000000);
        tick();
        checks++; if ({illegal, reg_write, mem_write} !== 3'b100) begin failures++; $display("FAIL ill_op got=%b exp=100", {illegal, reg_write, mem_write}); end
        set_instr(7'b0000011, 3'b011, 7'b0000000);
        tick();
        checks++; if ({illegal, reg_write, mem_write, result_src} !== 5'b10000) begin failures++; $display("FAIL ill_load got=%b exp=10000", {illegal, reg_write, mem_write, result_src}); end
        set_instr(7'b0110011, 3'b001, 7'b0100000);
        tick();
        checks++; if ({illegal, reg_write} !== 2'b10) begin failures++; $display("FAIL ill_rop got=%b exp=10", {illegal, reg_write}); end
        set_instr(7'b1100011, 3'b010, 7'b0000000);
        tick();
        checks++; if ({illegal, branch} !== 2'b10) begin failures++; $display("FAIL ill_branch got=%b exp=10", {illegal, branch}); end
        set_instr(7'b1100011, 3'b000, 7'b0000000);  // beq
        tick();
        checks++; if ({illegal, branch, alu_ctrl} !== 6'b01_0001) begin failures++; $display("FAIL beq_ctrl got=%b exp=010001", {illegal, branch, alu_ctrl}); end
    endtask

    task automatic test_stall_done();
        set_instr(7'b0110011, 3'b000, 7'b0000001);  // mul
        tick();
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        tick();
        stall = 1'b1;
        tick();
        checks++; if ({mdu_sel, mdu_done, mdu_start, busy} !== 4'b1100) begin failures++; $display("FAIL stall_done1 got=%b exp=1100", {mdu_sel, mdu_done, mdu_start, busy}); end
        tick();
        checks++; if ({mdu_done, mdu_start} !== 2'b10) begin failures++; $display("FAIL stall_done2 got=%b exp=10", {mdu_done, mdu_start}); end
        stall = 1'b0;
        tick();
        checks++; if ({mdu_sel, reg_write} !== 2'b01) begin failures++; $display("FAIL stall_release got=%b exp=01", {mdu_sel, reg_write}); end
    endtask

    task automatic test_stall_flush();
        set_instr(7'b0000011, 3'b010, 7'b0000000);  // lw while add sits in E
        stall = 1'b1; flush = 1'b1;
        tick();
        checks++; if ({reg_write, result_src} !== 3'b100) begin failures++; $display("FAIL sf_hold got=%b exp=100", {reg_write, result_src}); end
        stall = 1'b0; flush = 1'b0;
        tick();
        checks++; if ({reg_write, result_src} !== 3'b000) begin failures++; $display("FAIL sf_bubble got=%b exp=000", {reg_write, result_src}); end
        tick();
        checks++; if ({reg_write, result_src} !== 3'b101) begin failures++; $display("FAIL sf_load got=%b exp=101", {reg_write, result_src}); end
    endtask

    initial begin
        test_reset();
        test_alu_mem();
        test_mul();
        test_back_to_back();
        test_div();
        test_div_flush();
        test_reset_run();
        test_illegal();
        test_stall_done();
        test_stall_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
